// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the elastic pipeline stage register.
//   pipe_state_t : occupancy of the stage (EMPTY / HALF / FULL), 2 bits
//   PERF_CNT_W   : width of the optional performance counters
// -----------------------------------------------------------------------------
package pipe_pkg;

    localparam int PERF_CNT_W = 32;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,   // nothing held
        HALF  = 2'd1,   // main register valid
        FULL  = 2'd2    // main and skid registers valid
    } pipe_state_t;

endpackage : pipe_pkg

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at its all-ones value instead of wrapping.
//   clk   : rising-edge clock
//   reset : synchronous, active-high clear (highest priority)
//   inc   : count enable for this cycle
//   count : current count value
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // NOTE: clocked state is written with non-blocking assignments so every
    // flop samples pre-edge values, independent of process ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule : sat_counter

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
// Elastic pipeline stage register with a valid/ready handshake and a two-entry
// skid buffer. in_ready depends only on registered state (and reset), so there
// is no combinational path from out_ready to in_ready. flush and stall are
// hazard-unit overrides.
//
// Parameters
//   DATA_W     : payload width
//   BUBBLE_VAL : value on out_data while out_valid=0; also reset/flush value
// Ports
//   clk, reset          : clock, synchronous active-high reset
//   flush               : drop all held entries this cycle
//   stall               : block output transfer (input side keeps accepting)
//   in_valid / in_ready / in_data    : upstream handshake and payload
//   out_valid / out_ready / out_data : downstream handshake and payload
//   perf_stall_cnt, perf_flush_cnt   : saturating event counters, present only
//                                      when PIPE_STAGE_PERF_EN is defined
// -----------------------------------------------------------------------------
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                DATA_W     = 64,
    parameter logic [DATA_W-1:0] BUBBLE_VAL = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  stall,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_data
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [PERF_CNT_W-1:0] perf_stall_cnt,
    output logic [PERF_CNT_W-1:0] perf_flush_cnt
`endif
);

    pipe_state_t       state, state_nxt;
    logic [DATA_W-1:0] main_q, main_nxt;
    logic [DATA_W-1:0] skid_q, skid_nxt;
    logic              in_fire, out_fire;

    assign in_ready  = ~reset & (state != FULL);
    assign out_valid = (state != EMPTY);
    assign out_data  = out_valid ? main_q : BUBBLE_VAL;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready & ~stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= EMPTY;
            main_q <= BUBBLE_VAL;
            skid_q <= BUBBLE_VAL;
        end else begin
            state  <= state_nxt;
            main_q <= main_nxt;
            skid_q <= skid_nxt;
        end
    end

    // NOTE: every signal written here gets a default first, so no path through
    // the block leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        main_nxt  = main_q;
        skid_nxt  = skid_q;

        if (flush) begin
            // A coincident out_fire needs no action: downstream already took it.
            state_nxt = EMPTY;
            main_nxt  = BUBBLE_VAL;
            skid_nxt  = BUBBLE_VAL;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        state_nxt = HALF;
                        main_nxt  = in_data;
                    end
                end
                HALF: begin
                    if (in_fire && !out_fire) begin
                        state_nxt = FULL;
                        skid_nxt  = in_data;
                    end else if (out_fire && !in_fire) begin
                        state_nxt = EMPTY;
                    end else if (in_fire && out_fire) begin
                        main_nxt  = in_data;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only the output side can move.
                    if (out_fire) begin
                        state_nxt = HALF;
                        main_nxt  = skid_q;
                    end
                end
                default: begin
                    state_nxt = EMPTY;
                end
            endcase
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    logic stall_evt, flush_evt;

    // Cycles where held data could not leave, for either reason.
    assign stall_evt = out_valid & (stall | ~out_ready);
    assign flush_evt = flush & ~reset;

    sat_counter #(.WIDTH(PERF_CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_evt),
        .count (perf_stall_cnt)
    );

    sat_counter #(.WIDTH(PERF_CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush_evt),
        .count (perf_flush_cnt)
    );
`endif

endmodule : pipe_stage_reg

// File: tb/tb_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg
// Self-checking bench for pipe_stage_reg. A queue of held payloads (at most
// two) is the reference model; a negedge process compares the DUT against it
// every cycle, and directed sequences pin literal expectations.
// Counter checks are compiled in when PIPE_STAGE_PERF_EN is defined.
// -----------------------------------------------------------------------------
module tb_pipe_stage_reg;

    localparam int          DW     = 16;
    localparam logic [15:0] BUBBLE = 16'hDEAD;

    logic          clk;
    logic          reset, flush, stall;
    logic          in_valid, in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid, out_ready;
    logic [DW-1:0] out_data;
`ifdef PIPE_STAGE_PERF_EN
    logic [31:0]   perf_stall_cnt, perf_flush_cnt;
`endif

    int total = 0;
    int bad   = 0;
    bit chk_en = 0;

    logic [DW-1:0] model_q[$];
`ifdef PIPE_STAGE_PERF_EN
    logic [31:0]   m_stall, m_flush;
`endif

    pipe_stage_reg #(.DATA_W(DW), .BUBBLE_VAL(BUBBLE)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .stall     (stall),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a FIFO of at most two entries, advanced by the
    // handshake rules on each rising edge.
    always @(posedge clk) begin
        bit ov, ir;
        ov = (model_q.size() != 0);
        ir = !reset && (model_q.size() < 2);
        if (reset) begin
            model_q.delete();
        end else if (flush) begin
            model_q.delete();
        end else begin
            if (ov && out_ready && !stall) void'(model_q.pop_front());
            if (in_valid && ir) model_q.push_back(in_data);
        end
`ifdef PIPE_STAGE_PERF_EN
        if (reset) begin
            m_stall = 0;
            m_flush = 0;
        end else begin
            if (ov && (stall || !out_ready) && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
            if (flush && m_flush != 32'hFFFF_FFFF) m_flush = m_flush + 1;
        end
`endif
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("in_ready",  in_ready,  !reset && (model_q.size() < 2));
            check("out_valid", out_valid, model_q.size() != 0);
            check("out_data",  out_data,  (model_q.size() != 0) ? model_q[0] : BUBBLE);
`ifdef PIPE_STAGE_PERF_EN
            check("perf_stall_cnt", perf_stall_cnt, m_stall);
            check("perf_flush_cnt", perf_flush_cnt, m_flush);
`endif
        end
    end

    // Apply one cycle of inputs, then land 1 time unit after the edge.
    task automatic step(input logic r, input logic f, input logic s,
                        input logic iv, input logic [DW-1:0] d, input logic ordy);
        reset     = r;
        flush     = f;
        stall     = s;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; stall = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

        // Reset state
        step(1, 0, 0, 0, 16'h0, 0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data",  out_data,  BUBBLE);
        check("rst_in_ready",  in_ready,  1'b0);
        chk_en = 1;

        // Streaming 1,2,3,4 with out_ready=1
        for (int i = 1; i <= 4; i++) begin
            step(0, 0, 0, 1, 16'(i), 1);
            check("stream_data",     out_data,  64'(i));
            check("stream_in_ready", in_ready,  1'b1);
        end
        step(0, 0, 0, 0, 16'h0, 1);
        check("stream_drain_valid", out_valid, 1'b0);

        // Backpressure into FULL, then release in order
        step(0, 0, 0, 1, 16'hA, 0);
        step(0, 0, 0, 1, 16'hB, 0);
        check("bp_full_in_ready", in_ready, 1'b0);
        check("bp_full_data",     out_data, 16'hA);
        step(0, 0, 0, 0, 16'h0, 1);
        check("bp_second_data",   out_data, 16'hB);
        check("bp_second_ready",  in_ready, 1'b1);
        step(0, 0, 0, 0, 16'h0, 1);
        check("bp_empty_valid",   out_valid, 1'b0);

        // Flush while FULL with coincident input 0xC
        step(0, 0, 0, 1, 16'h1, 0);
        step(0, 0, 0, 1, 16'h2, 0);
        step(0, 1, 0, 1, 16'hC, 0);
        check("flush_valid", out_valid, 1'b0);
        check("flush_data",  out_data,  BUBBLE);
        step(0, 0, 0, 0, 16'h0, 1);
        check("flush_no_c",  out_valid, 1'b0);

        // Stall for 3 cycles holding 0x5
        step(1, 0, 0, 0, 16'h0, 1);
        step(0, 0, 0, 1, 16'h5, 1);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, 0, 16'h0, 1);
            check("stall_hold_data",  out_data,  16'h5);
            check("stall_hold_valid", out_valid, 1'b1);
        end
`ifdef PIPE_STAGE_PERF_EN
        check("stall_perf_cnt", perf_stall_cnt, 32'd3);
`endif
        step(0, 0, 0, 0, 16'h0, 1);
        check("stall_release", out_valid, 1'b0);

        // Reset while FULL
        step(0, 0, 0, 1, 16'h7, 0);
        step(0, 1, 0, 1, 16'h8, 0);
        step(0, 0, 0, 1, 16'h7, 0);
        step(0, 0, 0, 1, 16'h8, 0);
        step(1, 0, 0, 0, 16'h0, 1);
        check("rstfull_valid",    out_valid, 1'b0);
        check("rstfull_in_ready", in_ready,  1'b0);
        step(0, 0, 0, 0, 16'h0, 1);
        check("rstfull_after_valid", out_valid, 1'b0);
        check("rstfull_after_ready", in_ready,  1'b1);
`ifdef PIPE_STAGE_PERF_EN
        check("rstfull_stall_cnt", perf_stall_cnt, 32'd0);
        check("rstfull_flush_cnt", perf_flush_cnt, 32'd0);
`endif

        // Randomised traffic against the model
        for (int i = 0; i < 4000; i++) begin
            step(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 31) == 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 2) != 0),
                 16'($urandom),
                 ($urandom_range(0, 3) != 0));
        end

`ifdef PIPE_STAGE_PERF_EN
        // Saturation of the flush counter from a preloaded value
        chk_en = 0;
        step(1, 0, 0, 0, 16'h0, 1);
        force dut.u_flush_cnt.count = 32'hFFFF_FFFE;
        #1;
        release dut.u_flush_cnt.count;
        step(0, 1, 0, 0, 16'h0, 1);
        check("sat_first",  perf_flush_cnt, 32'hFFFF_FFFF);
        step(0, 1, 0, 0, 16'h0, 1);
        check("sat_second", perf_flush_cnt, 32'hFFFF_FFFF);
`endif

        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_pipe_stage_reg
